scr1_dmem_arbiter: RTL and testbench
====================================

// Module: scr1_dmem_arbiter
// PURPOSE
//  Shares one SCR1 DMEM-protocol slave (one dmem_router port) between two masters: M0 (core LSU) and M1 (crypto/DMA engine).
//  Address phase is req/req_ack; data phase ends on resp RDY_OK or RDY_ER. One transaction is outstanding at a time,
//  and a new address phase may overlap an RDY_OK response. Round-robin or fixed priority. A response watchdog turns a hung slave into RDY_ER.
// PARAMETERS
//  SCR1_ARB_FIXED_PRIO  0   1: M0 always wins; 0: round-robin between M0 and M1.
//  SCR1_ARB_TIMEOUT     255 Data-phase NOTRDY cycles before abort; 0 disables the watchdog.
//  SCR1_ARB_TCNT_W      8   Watchdog counter width; must hold SCR1_ARB_TIMEOUT.
// PORTS
//  clk          in   1                       Clock; all state on posedge.
//  rst          in   1                       Asynchronous, active-high reset.
//  mN_req       in   1                       Master N request (N=0,1).
//  mN_req_ack   out  1                       Master N address phase accepted.
//  mN_cmd       in   type_scr1_mem_cmd_e     Master N read/write command.
//  mN_width     in   type_scr1_mem_width_e   Master N access size.
//  mN_addr      in   SCR1_DMEM_AWIDTH        Master N address.
//  mN_wdata     in   SCR1_DMEM_DWIDTH        Master N write data.
//  mN_rdata     out  SCR1_DMEM_DWIDTH        Master N read data; 0 when N is not the owner.
//  mN_resp      out  type_scr1_mem_resp_e    Master N response; NOTRDY when N is not the owner.
//  s_req        out  1                       Slave request.
//  s_req_ack    in   1                       Slave address phase accepted.
//  s_cmd/s_width/s_addr/s_wdata  out  as mN  Granted master's fields, muxed.
//  s_rdata      in   SCR1_DMEM_DWIDTH        Slave read data.
//  s_resp       in   type_scr1_mem_resp_e    Slave response.
//  timeout_err  out  1                       One-cycle pulse when the watchdog aborts a transaction.
// BEHAVIOUR
//  - State: fsm {ADDR, DATA, DRAIN}, owner_r, rr_last, tcnt, timeout_err.
//  - Reset values: fsm=ADDR, owner_r=M0, rr_last=M1 (so M0 wins the first tie), tcnt=0, timeout_err=0.
//  - Outputs at reset: s_req=0, mN_req_ack=0, mN_resp=NOTRDY, mN_rdata=0.
//  - Window open (win) = fsm==ADDR | (fsm==DATA & s_resp==RDY_OK & no abort this cycle).
//  - gnt (combinational) when only one master requests: that master.
//  - gnt when both request: M0 if FIXED_PRIO; otherwise the master != rr_last.
//  - s_req = win & (m0_req|m1_req). s_cmd/width/addr/wdata = gnt master's fields. mN_req_ack = win & gnt==N & s_req_ack.
//  - Accept = s_req & s_req_ack. On accept: fsm<=DATA, owner_r<=gnt, rr_last<=gnt, tcnt<=0.
//  - DATA, owner response: owner's resp/rdata = s_resp/s_rdata; other master sees NOTRDY/0.
//  - DATA, s_resp RDY_OK with no accept: fsm<=ADDR.
//  - DATA, s_resp RDY_OK with accept: stay DATA. Back-to-back, zero bubble; the owner may change in that cycle.
//  - DATA, s_resp RDY_ER: fsm<=ADDR. No overlap: win=0 that cycle.
//  - DATA, s_resp NOTRDY: tcnt increments.
//  - Abort: when TIMEOUT!=0 & tcnt==TIMEOUT-1 & s_resp==NOTRDY:
//    owner resp=RDY_ER (rdata 0) that cycle, timeout_err<=1 next cycle for 1 cycle, fsm<=DRAIN.
//  - DRAIN: win=0, both masters see NOTRDY. First s_resp!=NOTRDY is discarded -> fsm<=ADDR.
//  - DRAIN is not watchdogged; a dead slave keeps the arbiter in DRAIN.
//  - A master keeps req and its fields stable until req_ack. The arbiter may switch gnt between cycles
//    while neither master is acked (round-robin only moves on accept).
//  - Reset asserted mid-transaction: return to reset state immediately. A stale slave response after reset is not tracked
//    (the integrator resets the slave together with the arbiter).
//  - Latency: arbitration adds 0 cycles. Response paths are combinational from s_resp/s_rdata.
//  - Unknown s_resp (enum default) is treated as NOTRDY.
// TESTING
//  1. M0 reads 0x0001_0000, slave acks immediately, RDY_OK after 2 cycles with 0xDEADBEEF
//     -> m0_req_ack in cycle 0, m0_rdata=0xDEADBEEF with RDY_OK in cycle 2, m1_resp NOTRDY throughout.
//  2. M0 and M1 request continuously, RR mode, slave returns RDY_OK every cycle -> grants M0,M1,M0,M1, no idle cycle.
//  3. Same stimulus with FIXED_PRIO=1 -> M0 granted every cycle, m1_req_ack stays 0.
//  4. TIMEOUT=4, slave holds NOTRDY -> owner sees RDY_ER in the 4th data cycle, timeout_err pulses once, no new grant
//     until the late RDY_OK, which is discarded; the next M1 request is then granted.
//  5. Slave returns RDY_ER while M1 is requesting -> no req_ack that cycle, M1 acked the following cycle.
//  6. rst pulsed while in DATA -> all outputs at reset values immediately; the next tie is won by M0.

Source files
------------

// File: rtl/scr1_dmem_arbiter.sv
// Two-master arbiter in front of one SCR1 DMEM-protocol slave, with overlap of
// the next address phase on RDY_OK and a response watchdog that turns a hung slave into RDY_ER.

package scr1_dmem_arb_pkg;
  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_arbiter
  import scr1_dmem_arb_pkg::*;
#(
  parameter bit          SCR1_ARB_FIXED_PRIO = 1'b0,
  parameter int unsigned SCR1_ARB_TIMEOUT    = 255,
  parameter int          SCR1_ARB_TCNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  // Master 0 (core LSU)
  input  logic                        m0_req,
  output logic                        m0_req_ack,
  input  type_scr1_mem_cmd_e          m0_cmd,
  input  type_scr1_mem_width_e        m0_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0] m0_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0] m0_wdata,
  output logic [SCR1_DMEM_DWIDTH-1:0] m0_rdata,
  output type_scr1_mem_resp_e         m0_resp,
  // Master 1 (crypto/DMA engine)
  input  logic                        m1_req,
  output logic                        m1_req_ack,
  input  type_scr1_mem_cmd_e          m1_cmd,
  input  type_scr1_mem_width_e        m1_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0] m1_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0] m1_wdata,
  output logic [SCR1_DMEM_DWIDTH-1:0] m1_rdata,
  output type_scr1_mem_resp_e         m1_resp,
  // Shared slave
  output logic                        s_req,
  input  logic                        s_req_ack,
  output type_scr1_mem_cmd_e          s_cmd,
  output type_scr1_mem_width_e        s_width,
  output logic [SCR1_DMEM_AWIDTH-1:0] s_addr,
  output logic [SCR1_DMEM_DWIDTH-1:0] s_wdata,
  input  logic [SCR1_DMEM_DWIDTH-1:0] s_rdata,
  input  type_scr1_mem_resp_e         s_resp,
  output logic                        timeout_err
);

  typedef enum logic [1:0] {
    ST_ADDR  = 2'd0,
    ST_DATA  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_fsm_e;

  localparam bit                       WDOG_EN   = (SCR1_ARB_TIMEOUT != 0);
  localparam logic [SCR1_ARB_TCNT_W-1:0] TCNT_LAST = SCR1_ARB_TCNT_W'(SCR1_ARB_TIMEOUT - 1);

  arb_fsm_e                   fsm;
  logic                       owner_r;   // 0: M0, 1: M1
  logic                       rr_last;
  logic [SCR1_ARB_TCNT_W-1:0] tcnt;

  logic                       resp_ok, resp_er, resp_nr;
  logic                       in_data, abort, win, gnt, accept;
  type_scr1_mem_resp_e        owner_resp;
  logic [SCR1_DMEM_DWIDTH-1:0] owner_rdata;

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    resp_ok = (s_resp == SCR1_MEM_RESP_RDY_OK);
    resp_er = (s_resp == SCR1_MEM_RESP_RDY_ER);
    resp_nr = ~(resp_ok | resp_er);  // encodings outside the enum behave as NOTRDY
    in_data = (fsm == ST_DATA);

    abort = WDOG_EN & in_data & resp_nr & (tcnt == TCNT_LAST);
    win   = (fsm == ST_ADDR) | (in_data & resp_ok);

    gnt = m1_req;
    if (m0_req & m1_req) begin
      gnt = SCR1_ARB_FIXED_PRIO ? 1'b0 : ~rr_last;
    end

    // Held low during reset so the slave sees no request while state is being cleared.
    s_req      = win & (m0_req | m1_req) & ~rst;
    accept     = s_req & s_req_ack;
    m0_req_ack = accept & ~gnt;
    m1_req_ack = accept & gnt;

    s_cmd   = gnt ? m1_cmd   : m0_cmd;
    s_width = gnt ? m1_width : m0_width;
    s_addr  = gnt ? m1_addr  : m0_addr;
    s_wdata = gnt ? m1_wdata : m0_wdata;

    owner_resp  = s_resp;
    owner_rdata = s_rdata;
    if (abort) begin
      owner_resp  = SCR1_MEM_RESP_RDY_ER;
      owner_rdata = '0;
    end else if (resp_nr) begin
      owner_resp  = SCR1_MEM_RESP_NOTRDY;
    end

    m0_resp  = SCR1_MEM_RESP_NOTRDY;
    m0_rdata = '0;
    m1_resp  = SCR1_MEM_RESP_NOTRDY;
    m1_rdata = '0;
    if (in_data & ~owner_r) begin
      m0_resp  = owner_resp;
      m0_rdata = owner_rdata;
    end
    if (in_data & owner_r) begin
      m1_resp  = owner_resp;
      m1_rdata = owner_rdata;
    end
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= ST_ADDR;
      owner_r     <= 1'b0;
      rr_last     <= 1'b1;
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= abort;
      if (accept) begin
        // Also covers the overlapped case: RDY_OK retires the old owner in the same cycle.
        fsm     <= ST_DATA;
        owner_r <= gnt;
        rr_last <= gnt;
        tcnt    <= '0;
      end else begin
        case (fsm)
          ST_DATA: begin
            if (!resp_nr)   fsm  <= ST_ADDR;
            else if (abort) fsm  <= ST_DRAIN;
            else            tcnt <= tcnt + 1'b1;
          end
          // The late response of an aborted access is swallowed here.
          ST_DRAIN: begin
            if (!resp_nr) fsm <= ST_ADDR;
          end
          default: fsm <= ST_ADDR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scr1_dmem_arbiter.sv
// Bench for scr1_dmem_arbiter: directed vector table, reset corner case and a random
// run against a transaction-level model, on a round-robin and a fixed-priority instance.

module tb_scr1_dmem_arbiter;
  import scr1_dmem_arb_pkg::*;

  localparam int TO = 4;
  localparam logic [1:0] NR = 2'd0, OK = 2'd1, ER = 2'd2;
  localparam logic [31:0] M0_ADDR = 32'h0001_0000, M1_ADDR = 32'h0002_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic m0_req, m1_req, s_req_ack;
  type_scr1_mem_cmd_e   m0_cmd, m1_cmd;
  type_scr1_mem_width_e m0_width, m1_width;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;
  type_scr1_mem_resp_e  s_resp;

  logic a_m0_ack, a_m1_ack, a_s_req, a_terr, b_m0_ack, b_m1_ack, b_s_req, b_terr;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
  type_scr1_mem_resp_e  a_m0_resp, a_m1_resp, b_m0_resp, b_m1_resp;
  type_scr1_mem_cmd_e   a_s_cmd, b_s_cmd;
  type_scr1_mem_width_e a_s_width, b_s_width;

  scr1_dmem_arbiter #(.SCR1_ARB_FIXED_PRIO(1'b0), .SCR1_ARB_TIMEOUT(TO), .SCR1_ARB_TCNT_W(3)) dut_rr (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_req_ack(a_m0_ack), .m0_cmd(m0_cmd), .m0_width(m0_width),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(a_m0_rdata), .m0_resp(a_m0_resp),
    .m1_req(m1_req), .m1_req_ack(a_m1_ack), .m1_cmd(m1_cmd), .m1_width(m1_width),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(a_m1_rdata), .m1_resp(a_m1_resp),
    .s_req(a_s_req), .s_req_ack(s_req_ack), .s_cmd(a_s_cmd), .s_width(a_s_width),
    .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_rdata(s_rdata), .s_resp(s_resp),
    .timeout_err(a_terr)
  );

  scr1_dmem_arbiter #(.SCR1_ARB_FIXED_PRIO(1'b1), .SCR1_ARB_TIMEOUT(TO), .SCR1_ARB_TCNT_W(8)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_req_ack(b_m0_ack), .m0_cmd(m0_cmd), .m0_width(m0_width),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(b_m0_rdata), .m0_resp(b_m0_resp),
    .m1_req(m1_req), .m1_req_ack(b_m1_ack), .m1_cmd(m1_cmd), .m1_width(m1_width),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(b_m1_rdata), .m1_resp(b_m1_resp),
    .s_req(b_s_req), .s_req_ack(s_req_ack), .s_cmd(b_s_cmd), .s_width(b_s_width),
    .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_rdata(s_rdata), .s_resp(s_resp),
    .timeout_err(b_terr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0; s_req_ack = 1'b0;
    s_resp = SCR1_MEM_RESP_NOTRDY; s_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst_before;
    bit          m0, m1, ack;
    logic [1:0]  resp;
    logic [31:0] rdata;
    bit          e_sreq;
    bit   [1:0]  e_acka;   // {m1,m0} of round-robin instance
    bit   [1:0]  e_ackb;   // {m1,m0} of fixed-priority instance
    logic [1:0]  e_r0, e_r1;
    logic [31:0] e_rd0;
    bit          e_terr;
  } vec_t;

  vec_t vecs[$];

  task automatic run_table();
    vecs = '{
      // single read by M0, RDY_OK two cycles after the address phase
      '{1, 1,0,1, NR, 32'h0,         1, 2'b01, 2'b01, NR, NR, 32'h0,         0},
      '{0, 0,0,0, NR, 32'h0,         0, 2'b00, 2'b00, NR, NR, 32'h0,         0},
      '{0, 0,0,0, OK, 32'hDEADBEEF,  0, 2'b00, 2'b00, OK, NR, 32'hDEADBEEF,  0},
      // both masters requesting, slave answers RDY_OK every cycle
      '{1, 1,1,1, OK, 32'h0,         1, 2'b01, 2'b01, NR, NR, 32'h0,         0},
      '{0, 1,1,1, OK, 32'hA1,        1, 2'b10, 2'b01, OK, NR, 32'hA1,        0},
      '{0, 1,1,1, OK, 32'hA2,        1, 2'b01, 2'b01, NR, OK, 32'h0,         0},
      '{0, 1,1,1, OK, 32'hA3,        1, 2'b10, 2'b01, OK, NR, 32'hA3,        0},
      // hung slave: abort in the 4th data cycle, drain swallows the late RDY_OK
      '{1, 1,0,1, NR, 32'h0,         1, 2'b01, 2'b01, NR, NR, 32'h0,         0},
      '{0, 0,0,0, NR, 32'h0,         0, 2'b00, 2'b00, NR, NR, 32'h0,         0},
      '{0, 0,0,0, NR, 32'h0,         0, 2'b00, 2'b00, NR, NR, 32'h0,         0},
      '{0, 0,0,0, NR, 32'h0,         0, 2'b00, 2'b00, NR, NR, 32'h0,         0},
      '{0, 0,0,0, NR, 32'h1234,      0, 2'b00, 2'b00, ER, NR, 32'h0,         0},
      '{0, 0,1,1, NR, 32'h0,         0, 2'b00, 2'b00, NR, NR, 32'h0,         1},
      '{0, 0,1,1, NR, 32'h0,         0, 2'b00, 2'b00, NR, NR, 32'h0,         0},
      '{0, 0,1,1, OK, 32'h55,        0, 2'b00, 2'b00, NR, NR, 32'h0,         0},
      '{0, 0,1,1, NR, 32'h0,         1, 2'b10, 2'b10, NR, NR, 32'h0,         0},
      // RDY_ER closes the window for one cycle
      '{1, 1,0,1, NR, 32'h0,         1, 2'b01, 2'b01, NR, NR, 32'h0,         0},
      '{0, 0,1,1, ER, 32'h77,        0, 2'b00, 2'b00, ER, NR, 32'h77,        0},
      '{0, 0,1,1, NR, 32'h0,         1, 2'b10, 2'b10, NR, NR, 32'h0,         0}
    };
    m0_addr = M0_ADDR; m0_cmd = SCR1_MEM_CMD_RD; m0_width = SCR1_MEM_WIDTH_WORD; m0_wdata = 32'h0;
    m1_addr = M1_ADDR; m1_cmd = SCR1_MEM_CMD_WR; m1_width = SCR1_MEM_WIDTH_BYTE; m1_wdata = 32'hCAFE;
    foreach (vecs[i]) begin
      if (vecs[i].rst_before) begin
        do_reset();
        check($sformatf("v%0d reset terr", i), a_terr, 1'b0);
      end
      m0_req = vecs[i].m0; m1_req = vecs[i].m1; s_req_ack = vecs[i].ack;
      s_resp = type_scr1_mem_resp_e'(vecs[i].resp); s_rdata = vecs[i].rdata;
      @(negedge clk);
      check($sformatf("v%0d s_req", i),  a_s_req, vecs[i].e_sreq);
      check($sformatf("v%0d ack_rr", i), {a_m1_ack, a_m0_ack}, vecs[i].e_acka);
      check($sformatf("v%0d ack_fp", i), {b_m1_ack, b_m0_ack}, vecs[i].e_ackb);
      check($sformatf("v%0d m0_resp", i), a_m0_resp, vecs[i].e_r0);
      check($sformatf("v%0d m1_resp", i), a_m1_resp, vecs[i].e_r1);
      check($sformatf("v%0d m0_rdata", i), a_m0_rdata, vecs[i].e_rd0);
      check($sformatf("v%0d terr", i), a_terr, vecs[i].e_terr);
      if (vecs[i].e_sreq)
        check($sformatf("v%0d s_addr", i), a_s_addr, vecs[i].e_acka[1] ? M1_ADDR : M0_ADDR);
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- reset in the middle of a transaction ----------------
  task automatic run_reset_mid();
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1; s_req_ack = 1'b1;
    s_resp = SCR1_MEM_RESP_NOTRDY;
    @(negedge clk);
    check("rst_mid first tie m0", {a_m1_ack, a_m0_ack}, 2'b01);
    @(posedge clk);
    #1;
    s_resp = SCR1_MEM_RESP_RDY_OK; s_rdata = 32'h600D;
    #2 rst = 1'b1;
    #1;
    check("rst_mid s_req",    a_s_req, 1'b0);
    check("rst_mid acks",     {a_m1_ack, a_m0_ack, b_m1_ack, b_m0_ack}, 4'b0000);
    check("rst_mid m0_resp",  a_m0_resp, NR);
    check("rst_mid m1_resp",  a_m1_resp, NR);
    check("rst_mid m0_rdata", a_m0_rdata, 32'h0);
    check("rst_mid terr",     a_terr, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    s_resp = SCR1_MEM_RESP_NOTRDY;
    @(negedge clk);
    check("rst_mid next tie m0", {a_m1_ack, a_m0_ack}, 2'b01);
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level reference model ----------------
  // Per instance: whether an access is outstanding, whether it was aborted and is
  // waiting for the slave to finish, who owns it, and how long it has waited.
  bit busy[2], drain[2], own[2], last[2], terr_q[2];
  int age[2];

  typedef struct {
    bit          sreq, ack0, ack1, choice, abort, terr;
    logic [1:0]  r0, r1;
    logic [31:0] rd0, rd1;
  } exp_t;

  function automatic exp_t model(input int k);
    exp_t e;
    bit ok, er, nr, open, live;
    logic [1:0]  r;
    logic [31:0] rd;
    ok = (s_resp == SCR1_MEM_RESP_RDY_OK);
    er = (s_resp == SCR1_MEM_RESP_RDY_ER);
    nr = !ok && !er;
    live = busy[k] && !drain[k];
    e.abort = live && nr && (age[k] == TO - 1);
    open = !busy[k] || (live && ok);
    if (m0_req && m1_req) e.choice = (k == 1) ? 1'b0 : !last[k];
    else                  e.choice = m1_req;
    e.sreq = open && (m0_req || m1_req);
    e.ack0 = e.sreq && s_req_ack && !e.choice;
    e.ack1 = e.sreq && s_req_ack && e.choice;
    r  = e.abort ? ER : (nr ? NR : logic'(2'b0) | s_resp);
    rd = e.abort ? 32'h0 : s_rdata;
    e.r0  = (live && !own[k]) ? r : NR;
    e.rd0 = (live && !own[k]) ? rd : 32'h0;
    e.r1  = (live && own[k])  ? r : NR;
    e.rd1 = (live && own[k])  ? rd : 32'h0;
    e.terr = terr_q[k];
    return e;
  endfunction

  task automatic model_step(input int k, input exp_t e);
    bit done;
    done = (s_resp == SCR1_MEM_RESP_RDY_OK) || (s_resp == SCR1_MEM_RESP_RDY_ER);
    terr_q[k] = e.abort;
    if (e.ack0 || e.ack1) begin
      busy[k] = 1'b1; drain[k] = 1'b0; own[k] = e.choice; last[k] = e.choice; age[k] = 0;
    end else if (busy[k] && !drain[k]) begin
      if (done)         busy[k] = 1'b0;
      else if (e.abort) drain[k] = 1'b1;
      else              age[k]++;
    end else if (drain[k] && done) begin
      busy[k] = 1'b0; drain[k] = 1'b0;
    end
  endtask

  task automatic cmp(input string p, input exp_t e, input logic sreq, input logic ack0,
                     input logic ack1, input logic [1:0] r0, input logic [1:0] r1,
                     input logic [31:0] rd0, input logic [31:0] rd1, input logic terr,
                     input logic [31:0] saddr, input logic [31:0] swdata);
    check({p, " s_req"}, sreq, e.sreq);
    check({p, " acks"}, {ack1, ack0}, {e.ack1, e.ack0});
    check({p, " m0_resp"}, r0, e.r0);
    check({p, " m1_resp"}, r1, e.r1);
    check({p, " m0_rdata"}, rd0, e.rd0);
    check({p, " m1_rdata"}, rd1, e.rd1);
    check({p, " terr"}, terr, e.terr);
    if (e.sreq) begin
      check({p, " s_addr"},  saddr,  e.choice ? m1_addr  : m0_addr);
      check({p, " s_wdata"}, swdata, e.choice ? m1_wdata : m0_wdata);
    end
  endtask

  task automatic new_m0();
    m0_req   = ($urandom_range(0, 9) < 7);
    m0_cmd   = type_scr1_mem_cmd_e'($urandom_range(0, 1));
    m0_width = type_scr1_mem_width_e'($urandom_range(0, 3));
    m0_addr  = $urandom; m0_wdata = $urandom;
  endtask

  task automatic new_m1();
    m1_req   = ($urandom_range(0, 9) < 7);
    m1_cmd   = type_scr1_mem_cmd_e'($urandom_range(0, 1));
    m1_width = type_scr1_mem_width_e'($urandom_range(0, 3));
    m1_addr  = $urandom; m1_wdata = $urandom;
  endtask

  task automatic run_random(input int ncyc);
    exp_t ea, eb;
    int r;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      busy[k] = 0; drain[k] = 0; own[k] = 0; last[k] = 1; terr_q[k] = 0; age[k] = 0;
    end
    new_m0(); new_m1();
    for (int c = 0; c < ncyc; c++) begin
      s_req_ack = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r < 5)       s_resp = SCR1_MEM_RESP_NOTRDY;
      else if (r < 8)  s_resp = SCR1_MEM_RESP_RDY_OK;
      else if (r == 8) s_resp = SCR1_MEM_RESP_RDY_ER;
      else             s_resp = type_scr1_mem_resp_e'(2'b11);
      s_rdata = $urandom;
      @(negedge clk);
      ea = model(0);
      eb = model(1);
      cmp($sformatf("rnd%0d rr", c), ea, a_s_req, a_m0_ack, a_m1_ack, a_m0_resp, a_m1_resp,
          a_m0_rdata, a_m1_rdata, a_terr, a_s_addr, a_s_wdata);
      cmp($sformatf("rnd%0d fp", c), eb, b_s_req, b_m0_ack, b_m1_ack, b_m0_resp, b_m1_resp,
          b_m0_rdata, b_m1_rdata, b_terr, b_s_addr, b_s_wdata);
      @(posedge clk);
      model_step(0, ea);
      model_step(1, eb);
      #1;
      // masters hold their request until the round-robin instance acknowledges it
      if (!m0_req || ea.ack0) new_m0();
      if (!m1_req || ea.ack1) new_m1();
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 0; m1_req = 0; s_req_ack = 0;
    m0_cmd = SCR1_MEM_CMD_RD; m1_cmd = SCR1_MEM_CMD_RD;
    m0_width = SCR1_MEM_WIDTH_WORD; m1_width = SCR1_MEM_WIDTH_WORD;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    s_rdata = '0; s_resp = SCR1_MEM_RESP_NOTRDY;
    #1;
    check("por s_req", a_s_req, 1'b0);
    check("por m0_resp", a_m0_resp, NR);
    run_table();
    run_reset_mid();
    run_random(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
